// File: rtl/pe_dmem_banked_pkg.sv
// Shared constants and types for the banked PE data memory.
// The DEF_PE_* values stand in for the common def-pe.v defaults.
package pe_dmem_banked_pkg;
   localparam int DEF_PE_DATA_WIDTH        = 32;
   localparam int DEF_PE_RAM_ADDR_BITS     = 10;
   localparam int DEF_PE_DMEM_NUM_BANKS    = 4;
   localparam int DEF_PE_DMEM_STARVE_LIMIT = 4;

   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_BUS,
      GNT_CORE
   } gnt_e;

   function automatic int bank_bits(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction
endpackage

// File: rtl/pe_dmem_banked_if.sv
// Bus and core access ports of the banked data memory.
interface pe_dmem_banked_if #(
   parameter int DATA_WIDTH = pe_dmem_banked_pkg::DEF_PE_DATA_WIDTH,
   parameter int ADDR_BITS  = pe_dmem_banked_pkg::DEF_PE_RAM_ADDR_BITS
);
   logic                      iBus_Valid;
   logic                      oBus_Ready;
   logic [ADDR_BITS+1:0]      iBus_Address;
   logic                      iBus_Write_Enable;
   logic [DATA_WIDTH/8-1:0]   iBus_Byte_Enable;
   logic [DATA_WIDTH-1:0]     iBus_Write_Data;
   logic                      oBus_Read_Valid;
   logic [DATA_WIDTH-1:0]     oBus_Read_Data;
   logic                      iCore_Valid;
   logic                      iCore_Write_Enable;
   logic [DATA_WIDTH/8-1:0]   iCore_Byte_Select;
   logic [ADDR_BITS-1:0]      iCore_Address;
   logic [DATA_WIDTH-1:0]     iCore_Store_Data;
   logic [DATA_WIDTH-1:0]     oCore_Read_Data;
   logic                      oCore_Stall;

   modport slave (
      input  iBus_Valid, iBus_Address, iBus_Write_Enable, iBus_Byte_Enable, iBus_Write_Data,
      input  iCore_Valid, iCore_Write_Enable, iCore_Byte_Select, iCore_Address, iCore_Store_Data,
      output oBus_Ready, oBus_Read_Valid, oBus_Read_Data, oCore_Read_Data, oCore_Stall
   );
   modport master (
      output iBus_Valid, iBus_Address, iBus_Write_Enable, iBus_Byte_Enable, iBus_Write_Data,
      output iCore_Valid, iCore_Write_Enable, iCore_Byte_Select, iCore_Address, iCore_Store_Data,
      input  oBus_Ready, oBus_Read_Valid, oBus_Read_Data, oCore_Read_Data, oCore_Stall
   );
endinterface

// File: rtl/pe_dmem_bank.sv
// One single-port memory bank: byte-lane write enables, registered read (old data on collision).
module pe_dmem_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int ROW_W      = 8
) (
   input  logic                    clk_i,
   input  logic                    en_i,
   input  logic [DATA_WIDTH/8-1:0] we_i,
   input  logic [ROW_W-1:0]        addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);
   localparam int NL = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [2**ROW_W];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Contents are deliberately never reset.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int i = 0; i < NL; i++)
            if (we_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/pe_dmem_banked.sv
// Word-interleaved banked data memory shared by a system bus and a PE core.
// Core wins same-bank conflicts until the bus has lost STARVE_LIMIT times in a row.
module pe_dmem_banked
   import pe_dmem_banked_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_PE_DATA_WIDTH,
   parameter int ADDR_BITS    = DEF_PE_RAM_ADDR_BITS,
   parameter int NUM_BANKS    = DEF_PE_DMEM_NUM_BANKS,
   parameter int STARVE_LIMIT = DEF_PE_DMEM_STARVE_LIMIT
) (
   input logic             iClk,
   input logic             iReset,
   pe_dmem_banked_if.slave mem
);
   localparam int NL    = DATA_WIDTH / 8;
   localparam int BB    = bank_bits(NUM_BANKS);
   localparam int BW    = (BB == 0) ? 1 : BB;
   localparam int ROW_W = ADDR_BITS - BB;

   logic [ADDR_BITS-1:0]                  bus_word;
   logic [BW-1:0]                         bus_bank, core_bank, bus_bank_q, core_bank_q;
   logic [ROW_W-1:0]                      bus_row, core_row;
   logic                                  conflict, bus_win, bus_ready, bus_acc, core_acc;
   logic [STARVE_W-1:0]                   starve_q, starve_d;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rdata;
   logic                                  bus_rd_q, core_rd_q;
   logic [NL-1:0]                         core_sel_q;
   logic [DATA_WIDTH-1:0]                 bus_data_q, bus_data_d, core_data_q, core_data_d;
   logic [DATA_WIDTH-1:0]                 bus_rdata, core_rdata;
   logic                                  bus_addr_unused;

   assign bus_word        = mem.iBus_Address[ADDR_BITS+1:2];
   assign bus_addr_unused = ^mem.iBus_Address[1:0];
   assign bus_bank        = BW'(bus_word % NUM_BANKS);
   assign core_bank       = BW'(mem.iCore_Address % NUM_BANKS);
   assign bus_row         = ROW_W'(bus_word >> BB);
   assign core_row        = ROW_W'(mem.iCore_Address >> BB);

   assign conflict = !iReset && mem.iBus_Valid && mem.iCore_Valid && (bus_bank == core_bank);
   assign bus_win  = conflict && (starve_q == STARVE_W'(STARVE_LIMIT));
   assign bus_ready = !iReset && !(conflict && !bus_win);
   assign bus_acc  = mem.iBus_Valid && bus_ready;
   assign core_acc = !iReset && mem.iCore_Valid && !bus_win;

   assign mem.oBus_Ready  = bus_ready;
   assign mem.oCore_Stall = bus_win;

   always_comb begin
      starve_d = starve_q;
      if (bus_acc || !mem.iBus_Valid)
         starve_d = '0;
      else if (conflict && starve_q != STARVE_W'(STARVE_LIMIT))
         starve_d = starve_q + 1'b1;
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      gnt_e                  gnt;
      logic                  en;
      logic [NL-1:0]         we;
      logic [ROW_W-1:0]      addr;
      logic [DATA_WIDTH-1:0] wdata;

      always_comb begin
         gnt = GNT_NONE;
         if (bus_acc && bus_bank == BW'(b))        gnt = GNT_BUS;
         else if (core_acc && core_bank == BW'(b)) gnt = GNT_CORE;
         en    = (gnt != GNT_NONE);
         we    = '0;
         addr  = bus_row;
         wdata = mem.iBus_Write_Data;
         if (gnt == GNT_BUS && mem.iBus_Write_Enable) we = mem.iBus_Byte_Enable;
         if (gnt == GNT_CORE) begin
            addr  = core_row;
            wdata = mem.iCore_Store_Data;
            if (mem.iCore_Write_Enable) we = mem.iCore_Byte_Select;
         end
      end

      pe_dmem_bank #(.DATA_WIDTH(DATA_WIDTH), .ROW_W(ROW_W)) u_bank (
         .clk_i   (iClk),
         .en_i    (en),
         .we_i    (we),
         .addr_i  (addr),
         .wdata_i (wdata),
         .rdata_o (bank_rdata[b])
      );
   end

   // Outputs show fresh bank data in the cycle after a read, else the held value.
   assign bus_rdata  = bank_rdata[bus_bank_q];
   assign core_rdata = bank_rdata[core_bank_q];
   assign bus_data_d = bus_rd_q ? bus_rdata : bus_data_q;

   always_comb begin
      core_data_d = core_data_q;
      for (int i = 0; i < NL; i++)
         if (core_rd_q && core_sel_q[i]) core_data_d[i*8 +: 8] = core_rdata[i*8 +: 8];
   end

   assign mem.oBus_Read_Valid = bus_rd_q;
   assign mem.oBus_Read_Data  = bus_data_d;
   assign mem.oCore_Read_Data = core_data_d;

   always_ff @(posedge iClk) begin
      if (iReset) begin
         starve_q    <= '0;
         bus_rd_q    <= 1'b0;
         core_rd_q   <= 1'b0;
         bus_bank_q  <= '0;
         core_bank_q <= '0;
         core_sel_q  <= '0;
         bus_data_q  <= '0;
         core_data_q <= '0;
      end else begin
         starve_q    <= starve_d;
         bus_rd_q    <= bus_acc && !mem.iBus_Write_Enable;
         core_rd_q   <= core_acc && !mem.iCore_Write_Enable;
         bus_bank_q  <= bus_bank;
         core_bank_q <= core_bank;
         core_sel_q  <= mem.iCore_Byte_Select;
         bus_data_q  <= bus_data_d;
         core_data_q <= core_data_d;
      end
   end
endmodule

// File: tb/tb_pe_dmem_banked.sv
// Directed plus randomized checks of pe_dmem_banked against a word-array reference model.
module tb_pe_dmem_banked;
   localparam int DW = 32;
   localparam int AB = 10;
   localparam int NB = 4;
   localparam int SL = 4;
   localparam int NL = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_dmem_banked_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) ifc ();

   pe_dmem_banked #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_BANKS(NB), .STARVE_LIMIT(SL)) dut (
      .iClk   (clk),
      .iReset (rst),
      .mem    (ifc)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [DW-1:0] mdl [0:(1<<AB)-1];
   int            m_starve;
   logic          exp_rv;
   logic [DW-1:0] exp_bd, exp_cd;
   logic          obs_ready, obs_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive, check combinational handshake, clock, check registered results.
   task automatic cycle(input logic r, input logic bv, input logic bwe, input int bw,
                        input logic [NL-1:0] bbe, input logic [DW-1:0] bwd,
                        input logic cv, input logic cwe, input int cw,
                        input logic [NL-1:0] csel, input logic [DW-1:0] cwd);
      logic conf, bwin, e_rdy, bacc, cacc;
      logic [1:0] lo;
      lo = 2'($urandom);
      rst                    = r;
      ifc.iBus_Valid         = bv;
      ifc.iBus_Address       = {bw[AB-1:0], lo};
      ifc.iBus_Write_Enable  = bwe;
      ifc.iBus_Byte_Enable   = bbe;
      ifc.iBus_Write_Data    = bwd;
      ifc.iCore_Valid        = cv;
      ifc.iCore_Write_Enable = cwe;
      ifc.iCore_Byte_Select  = csel;
      ifc.iCore_Address      = cw[AB-1:0];
      ifc.iCore_Store_Data   = cwd;

      conf  = !r && bv && cv && ((bw % NB) == (cw % NB));
      bwin  = conf && (m_starve == SL);
      e_rdy = !r && !(conf && !bwin);
      #1;
      obs_ready = ifc.oBus_Ready;
      obs_stall = ifc.oCore_Stall;
      chk("bus_ready", 64'(obs_ready), 64'(e_rdy));
      chk("core_stall", 64'(obs_stall), 64'(bwin));

      bacc = bv && e_rdy;
      cacc = !r && cv && !bwin;
      if (r) begin
         exp_rv = 1'b0; exp_bd = '0; exp_cd = '0; m_starve = 0;
      end else begin
         exp_rv = bacc && !bwe;
         if (exp_rv) exp_bd = mdl[bw];
         if (cacc && !cwe)
            for (int i = 0; i < NL; i++) if (csel[i]) exp_cd[i*8 +: 8] = mdl[cw][i*8 +: 8];
         if (bacc && bwe)
            for (int i = 0; i < NL; i++) if (bbe[i]) mdl[bw][i*8 +: 8] = bwd[i*8 +: 8];
         if (cacc && cwe)
            for (int i = 0; i < NL; i++) if (csel[i]) mdl[cw][i*8 +: 8] = cwd[i*8 +: 8];
         if (bacc || !bv) m_starve = 0;
         else if (m_starve < SL) m_starve++;
      end

      @(posedge clk);
      #1;
      chk("bus_rvalid", 64'(ifc.oBus_Read_Valid), 64'(exp_rv));
      chk("bus_rdata", 64'(ifc.oBus_Read_Data), 64'(exp_bd));
      chk("core_rdata", 64'(ifc.oCore_Read_Data), 64'(exp_cd));
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b0, 1'b0, 0, '0, '0);
   endtask

   initial begin
      m_starve = 0;
      // Reset with a bus read pending: nothing accepted, outputs cleared.
      cycle(1'b1, 1'b1, 1'b0, 4, '1, '0, 1'b1, 1'b0, 4, '1, '0);
      cycle(1'b1, 1'b1, 1'b0, 4, '1, '0, 1'b0, 1'b0, 0, '0, '0);
      chk("reset_ready", 64'(obs_ready), 64'd0);

      for (int w = 0; w < 32; w++)
         cycle(1'b0, 1'b1, 1'b1, w, '1, DW'($urandom), 1'b0, 1'b0, 0, '0, '0);

      // Partial-lane core store into a zeroed word.
      cycle(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1, 5, '1, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1, 5, 4'b0101, 32'hAABBCCDD);
      cycle(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b0, 5, '1, '0);
      chk("byte_select_read", 64'(ifc.oCore_Read_Data), 64'h00BB00DD);

      // Different banks in one cycle: both proceed.
      cycle(1'b0, 1'b1, 1'b1, 4, '1, 32'h12345678, 1'b1, 1'b1, 5, '1, 32'h55667788);
      chk("parallel_ready", 64'(obs_ready), 64'd1);
      chk("parallel_stall", 64'(obs_stall), 64'd0);
      cycle(1'b0, 1'b1, 1'b0, 4, '1, '0, 1'b1, 1'b0, 5, '1, '0);
      chk("bus_read_valid", 64'(ifc.oBus_Read_Valid), 64'd1);
      chk("bus_read_word4", 64'(ifc.oBus_Read_Data), 64'h12345678);
      chk("core_read_word5", 64'(ifc.oCore_Read_Data), 64'h55667788);

      // Sustained bank-2 conflict: bus starves SL cycles, then wins once.
      idle();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 2, '1, 32'hC0DE0000 + DW'(i), 1'b1, 1'b0, 6, '1, '0);
         if (i < SL) chk("starve_ready_low", 64'(obs_ready), 64'd0);
         else if (i == SL) begin
            chk("starve_bus_wins", 64'(obs_ready), 64'd1);
            chk("starve_core_stall", 64'(obs_stall), 64'd1);
         end else chk("starve_cleared", 64'(obs_ready), 64'd0);
      end

      // Reset during a bus read: dropped, memory preserved.
      cycle(1'b1, 1'b1, 1'b0, 4, '1, '0, 1'b0, 1'b0, 0, '0, '0);
      chk("rst_read_dropped", 64'(ifc.oBus_Read_Valid), 64'd0);
      chk("rst_bus_data", 64'(ifc.oBus_Read_Data), 64'd0);
      chk("rst_core_data", 64'(ifc.oCore_Read_Data), 64'd0);
      cycle(1'b0, 1'b1, 1'b0, 4, '1, '0, 1'b0, 1'b0, 0, '0, '0);
      chk("mem_preserved", 64'(ifc.oBus_Read_Data), 64'h12345678);

      for (int n = 0; n < 400; n++) begin
         logic r, bv, bwe, cv, cwe;
         logic [NL-1:0] bbe, csel;
         int bw, cw;
         r    = ($urandom_range(0, 59) == 0);
         bv   = ($urandom_range(0, 9) < 7);
         bwe  = 1'($urandom);
         bbe  = NL'($urandom);
         bw   = $urandom_range(0, 31);
         cv   = ($urandom_range(0, 9) < 7);
         cwe  = 1'($urandom);
         csel = NL'($urandom);
         cw   = $urandom_range(0, 31);
         cycle(r, bv, bwe, bw, bbe, DW'($urandom), cv, cwe, cw, csel, DW'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
